iccm_loader: RTL and testbench
==============================

Name: iccm_loader

Overview:
- Upstream programmer for the instruction memory (ICCM).
- Takes a byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes each word into the ICCM write port (we/addr/wdata) at consecutive word addresses.
- Holds the core in reset until an end-of-program marker arrives, then releases it and goes idle.

Parameters:
- AW, 12, ICCM word-address width; the address range is 0..2^AW-1.
- DW, 32, data word width; fixed at 4 bytes, and other values are unsupported.
- EOP_WORD, 32'h0000_0FFF, assembled word that terminates programming; it is never written.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- prog_en_i  in  1  level; 1 = loader armed and accepting bytes
- rx_valid_i  in  1  single-cycle strobe; rx_byte_i is valid
- rx_byte_i  in  8  received byte
- we_o  out  1  ICCM write enable, one cycle per word
- addr_o  out  AW  ICCM word address
- wdata_o  out  DW  ICCM write data
- core_rst_o  out  1  1 = hold core/system in reset
- done_o  out  1  sticky; program loaded successfully
- err_o  out  1  sticky; address overflow

Behaviour:
- Reset (rst_i=1 at a clock edge) sets the following outputs:
  - we_o=0, addr_o=0, wdata_o=0, done_o=0, err_o=0.
  - core_rst_o=1; the core is held until an explicit release.
- State is IDLE, byte counter is 0, word assembly register is 0.
- States:
  - IDLE: if prog_en_i=1, go to LOAD. If prog_en_i=0, core_rst_o drops to 0 on the next cycle and the state stays IDLE (bypass: boot from existing ICCM contents).
  - LOAD: each rx_valid_i=1 cycle places rx_byte_i into byte lane cnt of the assembly register (lane 0 = bits 7:0) and increments cnt (2-bit, wraps). On the strobe that fills lane 3 the full word is evaluated in the same cycle:
    - word == EOP_WORD: go to DONE; no write.
    - else: go to WRITE.
  - WRITE: one cycle. we_o=1, addr_o=current word pointer, wdata_o=assembled word.
    - Next cycle: we_o=0, pointer increments, return to LOAD.
    - Write latency is 1 cycle after the 4th byte strobe.
    - A rx_valid_i arriving during WRITE is accepted into lane 0 of the next word; no byte is ever dropped.
  - DONE: done_o=1, core_rst_o=0, both registered and asserted the cycle after the EOP byte. Stays in DONE until reset; further bytes are ignored.
  - ERR: entered when the pointer is at 2^AW-1 and WRITE completes (the last location is written, then the pointer would wrap).
    - err_o=1 and core_rst_o stays 1.
    - No further writes; the pointer does not wrap. Stays in ERR until reset.
- addr_o holds the last written address when we_o=0. wdata_o holds the last written data.
- prog_en_i deasserted while in LOAD: abort.
  - The partially assembled word is discarded and cnt is cleared.
  - Go to IDLE; the IDLE rule then releases the core. Words already written stay written.
  - done_o stays 0.
- core_rst_o is registered and glitch-free. It changes only on state transitions into IDLE-release or DONE.
- rst_i mid-word clears cnt and the pointer; the next load starts at address 0, byte lane 0.
- Byte strobes may be back-to-back (every cycle) or arbitrarily spaced; the throughput requirement is 1 byte per cycle.
- No backpressure: the ICCM write port always accepts.

Test Plan:
- Basic load: prog_en_i=1; send bytes 13 00 00 00, B7 02 00 00, FF 0F 00 00.
  - we_o pulses twice: addr 0 / 0x00000013, then addr 1 / 0x000002B7.
  - Third word causes no write; done_o=1 and core_rst_o=0 one cycle after the last byte.
- Back-to-back bytes: 12 bytes on consecutive cycles, EOP last.
  - Exactly 2 writes with correct data; no byte lost when a strobe coincides with WRITE.
- Bypass: after reset hold prog_en_i=0.
  - core_rst_o falls to 0 on the 2nd cycle; we_o never asserted; done_o=0.
- Abort: send 2 bytes, then drop prog_en_i, raise it again after a reset, and send 4 bytes AA BB CC DD.
  - Write at addr 0 with 0xDDCCBBAA; the partial word is never written.
- Overflow (AW=2): send 5 non-EOP words.
  - Writes at addr 0..3; err_o=1 after the 4th write; no 5th write; core_rst_o stays 1.
- Reset mid-operation: assert rst_i after 6 bytes.
  - All outputs return to reset values; the next word writes at addr 0.

Source files
------------

// File: rtl/iccm_loader_if.sv
// Byte-stream and ICCM write-port bundle for the ICCM loader.
// rx_valid_i is a one-cycle strobe with no ready: the loader takes every byte, and the ICCM always accepts we_o.
interface iccm_loader_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          prog_en_i;
  logic          rx_valid_i;
  logic [7:0]    rx_byte_i;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic          core_rst_o;
  logic          done_o;
  logic          err_o;
  logic [2:0]    state_o;

  modport master (
    output prog_en_i, rx_valid_i, rx_byte_i,
    input  we_o, addr_o, wdata_o, core_rst_o, done_o, err_o, state_o
  );

  modport slave (
    input  prog_en_i, rx_valid_i, rx_byte_i,
    output we_o, addr_o, wdata_o, core_rst_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/iccm_loader.sv
// Assembles little-endian words from a UART byte stream and writes them to the ICCM,
// holding the core in reset until the end-of-program word arrives.
module iccm_loader #(
  parameter int            AW       = 12,
  parameter int            DW       = 32,
  parameter logic [DW-1:0] EOP_WORD = 32'h0000_0FFF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  iccm_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t        state;
  logic [1:0]    cnt;
  logic [DW-1:0] word_q;
  logic [DW-1:0] word_next;
  logic [AW-1:0] ptr;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          core_rst;
  logic          done;
  logic          err;

  // Incoming byte merged into lane cnt; on the 4th byte this is the complete word.
  always_comb begin
    word_next = word_q;
    word_next[{cnt, 3'b000} +: 8] = bus.rx_byte_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cnt      <= 2'd0;
      word_q   <= '0;
      ptr      <= '0;
      we       <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.prog_en_i) state <= S_LOAD;
          else               core_rst <= 1'b0;
        end

        S_LOAD: begin
          if (!bus.prog_en_i) begin
            state  <= S_IDLE;
            cnt    <= 2'd0;
            word_q <= '0;
          end else if (bus.rx_valid_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              word_q <= '0;
              if (word_next == EOP_WORD) begin
                state    <= S_DONE;
                done     <= 1'b1;
                core_rst <= 1'b0;
              end else begin
                state <= S_WRITE;
                we    <= 1'b1;
                addr  <= ptr;
                wdata <= word_next;
              end
            end else begin
              word_q <= word_next;
            end
          end
        end

        // cnt has wrapped to 0 here, so a coincident byte lands in lane 0 of the next word.
        S_WRITE: begin
          we <= 1'b0;
          if (bus.rx_valid_i) begin
            word_q <= word_next;
            cnt    <= cnt + 2'd1;
          end
          if (ptr == '1) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            ptr   <= ptr + 1'b1;
            state <= S_LOAD;
          end
        end

        S_DONE: state <= S_DONE;
        S_ERR:  state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.we_o       = we;
  assign bus.addr_o     = addr;
  assign bus.wdata_o    = wdata;
  assign bus.core_rst_o = core_rst;
  assign bus.done_o     = done;
  assign bus.err_o      = err;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_iccm_loader.sv
// Drives two loaders (AW=12 and AW=2) with the same stream and checks both against
// a transaction-level model of the programming protocol.
module tb_iccm_loader;

  localparam logic [31:0] EOP = 32'h0000_0FFF;
  localparam int          INF = 32'h7fff_ffff;
  localparam int          P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_ERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog_en = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'd0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  // reference model state, one slot per DUT
  int          m_phase [2];
  logic [7:0]  m_bytes [2][$];
  logic [11:0] m_ptr   [2];
  logic [11:0] m_max   [2];
  int          done_cyc[2];
  int          err_cyc [2];
  int          rel_cyc [2];
  int          rst_chk [2];
  int          n_wr    [2];
  logic [43:0] exp_q   [2][$];
  int          exp_cyc [2][$];

  always #5 clk = ~clk;

  iccm_loader_if #(.AW(12), .DW(32)) bus0 ();
  iccm_loader_if #(.AW(2),  .DW(32)) bus1 ();

  assign bus0.prog_en_i  = prog_en;
  assign bus0.rx_valid_i = rx_valid;
  assign bus0.rx_byte_i  = rx_byte;
  assign bus1.prog_en_i  = prog_en;
  assign bus1.rx_valid_i = rx_valid;
  assign bus1.rx_byte_i  = rx_byte;

  iccm_loader #(.AW(12), .DW(32), .EOP_WORD(EOP)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));
  iccm_loader #(.AW(2),  .DW(32), .EOP_WORD(EOP)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Model: a byte is sampled at the posedge after it is driven (cycle cyc+1).
  task automatic model_step(input int d, input bit r, input bit p, input bit v, input logic [7:0] b);
    logic [31:0] w;
    if (r) begin
      m_phase[d] = P_IDLE;
      m_bytes[d].delete();
      m_ptr[d]   = 12'd0;
      exp_q[d].delete();
      exp_cyc[d].delete();
      done_cyc[d] = INF;
      err_cyc[d]  = INF;
      rel_cyc[d]  = INF;
      rst_chk[d]  = cyc + 1;
      return;
    end
    case (m_phase[d])
      P_IDLE: begin
        if (p) m_phase[d] = P_LOAD;
        else if (rel_cyc[d] == INF) rel_cyc[d] = cyc + 1;
      end
      P_LOAD: begin
        if (!p) begin
          m_phase[d] = P_IDLE;
          m_bytes[d].delete();
        end else if (v) begin
          m_bytes[d].push_back(b);
          if (m_bytes[d].size() == 4) begin
            w = {m_bytes[d][3], m_bytes[d][2], m_bytes[d][1], m_bytes[d][0]};
            m_bytes[d].delete();
            if (w == EOP) begin
              m_phase[d]  = P_DONE;
              done_cyc[d] = cyc + 1;
              if (rel_cyc[d] == INF) rel_cyc[d] = cyc + 1;
            end else begin
              exp_q[d].push_back({m_ptr[d], w});
              exp_cyc[d].push_back(cyc + 1);
              if (m_ptr[d] == m_max[d]) begin
                m_phase[d] = P_ERR;
                err_cyc[d] = cyc + 2;
              end else begin
                m_ptr[d] = m_ptr[d] + 12'd1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic mon(input int d, input logic we, input logic [43:0] wr, input logic [2:0] st,
                     input logic [2:0] dbg);
    string pfx;
    bit exp_we;
    logic [2:0] exp_st;
    pfx = (d == 0) ? "aw12" : "aw2";
    exp_we = (exp_cyc[d].size() > 0) && (exp_cyc[d][0] == cyc);
    chk({pfx, "_we"}, 64'(we), 64'(exp_we));
    if (we) n_wr[d]++;
    if (exp_we) begin
      if (we) chk({pfx, "_wr"}, 64'(wr), 64'(exp_q[d][0]));
      void'(exp_q[d].pop_front());
      void'(exp_cyc[d].pop_front());
    end
    exp_st = {cyc < rel_cyc[d], cyc >= done_cyc[d], cyc >= err_cyc[d]};
    chk({pfx, "_rst_done_err"}, 64'(st), 64'(exp_st));
    if (cyc == rst_chk[d]) chk({pfx, "_reset_addr_data_state"}, {17'd0, dbg, wr}, 64'd0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (started) begin
      mon(0, bus0.we_o, {bus0.addr_o, bus0.wdata_o},
          {bus0.core_rst_o, bus0.done_o, bus0.err_o}, bus0.state_o);
      mon(1, bus1.we_o, {10'd0, bus1.addr_o, bus1.wdata_o},
          {bus1.core_rst_o, bus1.done_o, bus1.err_o}, bus1.state_o);
    end
  end

  task automatic step(input bit r, input bit p, input bit v, input logic [7:0] b);
    @(negedge clk);
    rst = r; prog_en = p; rx_valid = v; rx_byte = b;
    if (r) started = 1'b1;
    model_step(0, r, p, v, b);
    model_step(1, r, p, v, b);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    n_wr[0] = 0;
    n_wr[1] = 0;
  endtask

  task automatic idle(input int n, input bit p);
    repeat (n) step(1'b0, p, 1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap, 1'b1);
    step(1'b0, 1'b1, 1'b1, b);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  task automatic arm();
    step(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    m_max[0] = 12'hFFF;
    m_max[1] = 12'h003;
    for (int d = 0; d < 2; d++) begin
      done_cyc[d] = INF; err_cyc[d] = INF; rel_cyc[d] = INF; rst_chk[d] = INF; n_wr[d] = 0;
    end

    // bypass: core released one cycle after reset, nothing written
    do_reset();
    idle(6, 1'b0);
    chk("bypass_writes", 64'(n_wr[0] + n_wr[1]), 64'd0);

    // basic load with random spacing
    do_reset();
    arm();
    send_word(32'h0000_0013, 3);
    send_word(32'h0000_02B7, 3);
    send_word(EOP, 3);
    idle(4, 1'b1);
    chk("basic_writes", 64'(n_wr[0]), 64'd2);

    // back-to-back bytes, then bytes after DONE are ignored
    do_reset();
    arm();
    send_word(32'h0000_0013, 0);
    send_word(32'h0000_02B7, 0);
    send_word(EOP, 0);
    send_word(32'h1234_5678, 0);
    idle(3, 1'b1);
    chk("b2b_writes", 64'(n_wr[0]), 64'd2);

    // abort after a partial word, then a fresh load
    do_reset();
    arm();
    send(8'h11, 0);
    send(8'h22, 1);
    idle(4, 1'b0);
    chk("abort_writes", 64'(n_wr[0]), 64'd0);
    do_reset();
    arm();
    send_word(32'hDDCC_BBAA, 2);
    send_word(EOP, 1);
    idle(3, 1'b1);

    // overflow on the AW=2 instance
    do_reset();
    arm();
    for (int i = 0; i < 5; i++) begin
      w = {8'($urandom_range(1, 255)), 24'($urandom)};
      send_word(w, 2);
    end
    idle(4, 1'b1);
    chk("ovf_writes_aw2", 64'(n_wr[1]), 64'd4);
    chk("ovf_writes_aw12", 64'(n_wr[0]), 64'd5);

    // reset mid-word, next load restarts at address 0
    do_reset();
    arm();
    for (int i = 0; i < 6; i++) send(8'($urandom), $urandom_range(0, 1));
    do_reset();
    arm();
    send_word(32'hCAFE_F00D, 1);
    send_word(EOP, 1);
    idle(3, 1'b1);

    // randomized programs
    for (int run = 0; run < 8; run++) begin
      do_reset();
      arm();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if (w == EOP) w = w ^ 32'h1;
        send_word(w, $urandom_range(0, 3));
      end
      send_word(EOP, 2);
      idle(5, 1'b1);
    end

    chk("aw12_pending", 64'(exp_q[0].size()), 64'd0);
    chk("aw2_pending", 64'(exp_q[1].size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
